// File: rtl/cv32e40p_rst_ctrl.sv
// cv32e40p_rst_ctrl: sequences the core's active-low reset and scores masked reset-value checks
module cv32e40p_rst_ctrl #(
  parameter int DUR_W   = 16,
  parameter int MIN_DUR = 2,
  parameter int OBS_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [DUR_W-1:0] req_duration_i,
  output logic             core_rst_no,
  output logic             busy_o,
  output logic             done_o,
  input  logic [OBS_W-1:0] obs_i,
  input  logic [OBS_W-1:0] obs_exp_i,
  input  logic [OBS_W-1:0] obs_mask_i,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] reset_cnt_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [CNT_W-1:0] mismatch_cnt_o
);
  typedef enum logic [1:0] {INIT, IDLE, ASSERT, RELEASE} state_t;
  state_t state, state_n;
  logic [DUR_W-1:0] cnt, cnt_n, dur;
  logic first, first_n, cmp, miss;
  always_comb begin
    dur = req_duration_i < DUR_W'(MIN_DUR) ? DUR_W'(MIN_DUR) : req_duration_i;
    miss = |((obs_i ^ obs_exp_i) & obs_mask_i);
    state_n = state;
    cnt_n = cnt;
    first_n = 1'b0;
    cmp = 1'b0;
    case (state)
      INIT: begin
        state_n = cnt <= DUR_W'(1) ? IDLE : INIT;
        cnt_n = cnt - DUR_W'(1);
      end
      IDLE: begin
        state_n = req_valid_i && req_ready_o ? ASSERT : IDLE;
        cnt_n = dur;
        first_n = req_valid_i && req_ready_o;
      end
      ASSERT: begin
        // the first asserted cycle is skipped while the core's own sync reset takes hold
        cmp = !first;
        state_n = cnt <= DUR_W'(1) ? RELEASE : ASSERT;
        cnt_n = cnt - DUR_W'(1);
      end
      RELEASE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= INIT;
      cnt <= DUR_W'(MIN_DUR);
      first <= 1'b0;
      core_rst_no <= 1'b0;
      req_ready_o <= 1'b0;
      busy_o <= 1'b1;
      done_o <= 1'b0;
      reset_cnt_o <= '0;
      match_cnt_o <= '0;
      mismatch_cnt_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      first <= first_n;
      core_rst_no <= state_n == IDLE || state_n == RELEASE;
      req_ready_o <= state_n == IDLE;
      busy_o <= state_n != IDLE;
      done_o <= state_n == RELEASE;
      reset_cnt_o <= clr_cnt_i ? '0 : reset_cnt_o + CNT_W'(state_n == RELEASE && ~&reset_cnt_o);
      match_cnt_o <= clr_cnt_i ? '0 : match_cnt_o + CNT_W'(cmp && !miss && ~&match_cnt_o);
      mismatch_cnt_o <= clr_cnt_i ? '0 : mismatch_cnt_o + CNT_W'(cmp && miss && ~&mismatch_cnt_o);
    end
  end
endmodule
